// File: rtl/mult_2x2_seq_ctrl.sv
// Sequential WIDTHxWIDTH unsigned multiplier that reuses one 2x2 cell.
// Ports: clk, rst_n, start, a, b in; busy, done, product out.

// multiplier_2x2: combinational 2-bit x 2-bit multiplier cell.
//   x, y : 2-bit operands
//   p    : 4-bit product (exact, or OR-based approximation when APPROX=1)
module multiplier_2x2 #(
    parameter bit APPROX = 1'b0
) (
    input  logic [1:0] x,
    input  logic [1:0] y,
    output logic [3:0] p
);

    generate
        if (APPROX) begin : g_apx
            // Middle bit ORs the cross terms and drops the carry,
            // so only 3*3 differs (7 instead of 9).
            assign p = {1'b0,
                        x[1] & y[1],
                        (x[1] & y[0]) | (x[0] & y[1]),
                        x[0] & y[0]};
        end else begin : g_exact
            assign p = {2'b00, x} * {2'b00, y};
        end
    endgenerate

endmodule

// mult_2x2_seq_ctrl: walks every 2-bit digit pair of the captured
// operands through one multiplier_2x2, one pair per clock.
//   clk, rst_n : clock, async active-low reset
//   start      : request, honoured only while busy is low
//   a, b       : operands, captured on an accepted start
//   busy       : high while running and in the done cycle
//   done       : one-cycle pulse when product is updated
//   product    : last completed result, 2*WIDTH bits
module mult_2x2_seq_ctrl #(
    parameter int WIDTH  = 8,
    parameter bit APPROX = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int D  = WIDTH / 2;
    localparam int PW = 2 * WIDTH;
    localparam int CW = (D > 1) ? $clog2(D) : 1;
    localparam logic [CW-1:0] LAST = CW'(D - 1);

    generate
        if (WIDTH < 2 || (WIDTH % 2) != 0) begin : g_bad_width
            $error("mult_2x2_seq_ctrl: WIDTH must be even and >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [PW-1:0]    acc;
    logic [CW-1:0]    i_q;
    logic [CW-1:0]    j_q;

    logic [1:0]       a_dig;
    logic [1:0]       b_dig;
    logic [3:0]       pp;
    logic [CW:0]      dsum;
    logic [PW-1:0]    pp_sh;
    logic [PW-1:0]    acc_nxt;

    // Digit i of a and digit j of b, straight from registers.
    assign a_dig = a_r[{i_q, 1'b0} +: 2];
    assign b_dig = b_r[{j_q, 1'b0} +: 2];

    multiplier_2x2 #(
        .APPROX (APPROX)
    ) u_cell (
        .x (a_dig),
        .y (b_dig),
        .p (pp)
    );

    // Partial product weight is 4^(i+j).
    assign dsum    = {1'b0, i_q} + {1'b0, j_q};
    assign pp_sh   = PW'(pp) << {dsum, 1'b0};
    assign acc_nxt = acc + pp_sh;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            a_r     <= '0;
            b_r     <= '0;
            acc     <= '0;
            i_q     <= '0;
            j_q     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_r   <= a;
                        b_r   <= b;
                        acc   <= '0;
                        i_q   <= '0;
                        j_q   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc <= acc_nxt;
                    if (j_q == LAST) begin
                        j_q <= '0;
                        if (i_q == LAST) begin
                            product <= acc_nxt;
                            done    <= 1'b1;
                            state   <= DONE;
                        end else begin
                            i_q <= i_q + CW'(1);
                        end
                    end else begin
                        j_q <= j_q + CW'(1);
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_2x2_seq_ctrl.sv
// Bench for mult_2x2_seq_ctrl: four instances (8/2 bit, exact/approx)
// checked every cycle against a cycle-count model of the sequencer.
module tb_mult_2x2_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;

    logic        dbusy [4];
    logic        ddone [4];
    logic [15:0] dprod [4];

    logic [15:0] p0, p1;
    logic [3:0]  p2, p3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mult_2x2_seq_ctrl #(.WIDTH(8), .APPROX(1'b0)) u8e (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .busy(dbusy[0]), .done(ddone[0]), .product(p0));
    mult_2x2_seq_ctrl #(.WIDTH(8), .APPROX(1'b1)) u8a (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .busy(dbusy[1]), .done(ddone[1]), .product(p1));
    mult_2x2_seq_ctrl #(.WIDTH(2), .APPROX(1'b0)) u2e (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a[1:0]), .b(b[1:0]),
        .busy(dbusy[2]), .done(ddone[2]), .product(p2));
    mult_2x2_seq_ctrl #(.WIDTH(2), .APPROX(1'b1)) u2a (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a[1:0]), .b(b[1:0]),
        .busy(dbusy[3]), .done(ddone[3]), .product(p3));

    assign dprod[0] = p0;
    assign dprod[1] = p1;
    assign dprod[2] = {12'd0, p2};
    assign dprod[3] = {12'd0, p3};

    function automatic int wid(int k);
        return (k < 2) ? 8 : 2;
    endfunction

    function automatic int ncyc(int k);
        return (wid(k) / 2) * (wid(k) / 2);
    endfunction

    function automatic bit [7:0] msk(int k, bit [7:0] v);
        return (k < 2) ? v : (v & 8'h03);
    endfunction

    // Reference product: exact is plain multiplication; approximate sums
    // digit products where only 3*3 is degraded to 7.
    function automatic bit [15:0] ref_mul(int w, bit ap, bit [7:0] x,
                                          bit [7:0] y);
        int s, dx, dy, pr;
        if (!ap) return 16'(int'(x) * int'(y));
        s = 0;
        for (int i = 0; i < w / 2; i++) begin
            for (int j = 0; j < w / 2; j++) begin
                dx = (int'(x) >> (2 * i)) & 3;
                dy = (int'(y) >> (2 * j)) & 3;
                pr = dx * dy;
                if (pr == 9) pr = 7;
                s += pr << (2 * (i + j));
            end
        end
        return 16'(s);
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Model: cnt = cycles of busy left; done in the last busy cycle.
    int        cnt   [4];
    bit [15:0] pend  [4];
    bit [15:0] mprod [4];

    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 4; k++) begin
            if (!rst_n) begin
                cnt[k]   <= 0;
                mprod[k] <= 16'd0;
            end else if (cnt[k] == 0) begin
                if (start) begin
                    cnt[k]  <= ncyc(k) + 1;
                    pend[k] <= ref_mul(wid(k), k % 2 == 1,
                                       msk(k, a), msk(k, b));
                end
            end else begin
                cnt[k] <= cnt[k] - 1;
                if (cnt[k] == 2) mprod[k] <= pend[k];
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("busy%0d", k), 32'(dbusy[k]), 32'(cnt[k] != 0));
            chk($sformatf("done%0d", k), 32'(ddone[k]), 32'(cnt[k] == 1));
            chk($sformatf("prod%0d", k), 32'(dprod[k]), 32'(mprod[k]));
        end
    end

    task automatic op(input bit [7:0] x, input bit [7:0] y, input int k,
                      input int nlat, output logic [15:0] res);
        int lat;
        bit got;
        @(posedge clk);
        #2 start = 1'b1; a = x; b = y;
        @(posedge clk);
        #2 start = 1'b0;
        lat = 0;
        got = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk);
            if (ddone[k] === 1'b1) got = 1'b1;
            else begin
                @(posedge clk);
                lat++;
            end
        end
        chk("op_timeout", 32'(got), 32'd1);
        chk("op_latency", 32'(lat), 32'(nlat));
        res = dprod[k];
    endtask

    task automatic idle_all();
        bit idle;
        idle = 1'b0;
        for (int c = 0; c < 40 && !idle; c++) begin
            @(negedge clk);
            idle = !(dbusy[0] || dbusy[1] || dbusy[2] || dbusy[3]);
        end
        chk("idle_timeout", 32'(idle), 32'd1);
    endtask

    logic [15:0] r;

    initial begin
        rst_n = 1'b1;
        start = 1'b0;
        a = 8'd0;
        b = 8'd0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_busy", 32'(dbusy[0]), 32'd0);
        chk("rst_done", 32'(ddone[0]), 32'd0);
        chk("rst_prod", 32'(dprod[0]), 32'd0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        chk("pin_13x11", 32'(ref_mul(8, 1'b0, 8'd13, 8'd11)), 32'd143);
        chk("pin_apx3x3", 32'(ref_mul(2, 1'b1, 8'd3, 8'd3)), 32'd7);
        chk("pin_ex3x3", 32'(ref_mul(2, 1'b0, 8'd3, 8'd3)), 32'd9);
        chk("pin_apxff", 32'(ref_mul(8, 1'b1, 8'hff, 8'hff)), 32'd50575);

        op(8'd13, 8'd11, 0, 16, r);
        chk("t1_prod", 32'(r), 32'd143);
        idle_all();

        op(8'd255, 8'd255, 0, 16, r);
        chk("t2_ffxff", 32'(r), 32'd65025);
        idle_all();
        op(8'd0, 8'd200, 0, 16, r);
        chk("t2_zero", 32'(r), 32'd0);
        idle_all();

        op(8'd3, 8'd3, 3, 1, r);
        chk("t4_apx", 32'(r), 32'd7);
        idle_all();
        op(8'd3, 8'd3, 2, 1, r);
        chk("t4_exact", 32'(r), 32'd9);
        idle_all();

        op(8'hff, 8'hff, 1, 16, r);
        chk("t5_apx", 32'(r), 32'd50575);
        idle_all();

        // Start held high with operands changing every cycle.
        for (int c = 0; c < 60; c++) begin
            @(posedge clk);
            #2 start = 1'b1; a = 8'($urandom); b = 8'($urandom);
        end
        @(posedge clk);
        #2 start = 1'b0;
        idle_all();

        // Reset five cycles into a run.
        @(posedge clk);
        #2 start = 1'b1; a = 8'hff; b = 8'hff;
        @(posedge clk);
        #2 start = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_busy", 32'(dbusy[0]), 32'd0);
        chk("t6_done", 32'(ddone[0]), 32'd0);
        chk("t6_prod", 32'(dprod[0]), 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        op(8'd13, 8'd11, 0, 16, r);
        chk("t6_after", 32'(r), 32'd143);
        idle_all();

        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #2 start = ($urandom_range(0, 3) == 0);
            a = 8'($urandom);
            b = 8'($urandom);
        end
        @(posedge clk);
        #2 start = 1'b0;
        idle_all();

        @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
